pc_fetch_unit: RTL
==================

# pc_fetch_unit

Instruction-fetch stage that owns the program counter and sits directly downstream of the next-PC select mux. It supplies `PC_add_4` to the mux and samples the mux output `Next_PC`. It fetches from instruction memory over a valid/ready request and valid response interface. Fetched instructions are delivered into a stallable, flushable IF/ID register for decode.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports (name, direction, width, meaning):
- `clk`, in, 1, sole clock; all state updates on the rising edge.
- `rst_n`, in, 1, reset; asynchronous, active-low.
- `Next_PC`, in, 32, next PC from the select mux; sampled on advance or redirect.
- `redirect`, in, 1, non-sequential PC resolved (jump/branch/JR); flush and refetch from `Next_PC`.
- `PC`, out, 32, current fetch PC.
- `PC_add_4`, out, 32, `PC + 4`, combinational, to the mux.
- `imem_req_valid`, out, 1, fetch request valid.
- `imem_req_ready`, in, 1, memory accepts the request.
- `imem_addr`, out, 32, `{PC[31:2], 2'b00}`.
- `imem_rsp_valid`, in, 1, response data valid.
- `imem_rsp_data`, in, 32, instruction word.
- `if_valid`, out, 1, IF/ID register holds a valid instruction.
- `if_instr`, out, 32, IF/ID instruction.
- `if_pc`, out, 32, PC of `if_instr`.
- `if_pc_add_4`, out, 32, `if_pc + 4`.
- `id_ready`, in, 1, decode consumes the IF/ID entry this cycle.

## Operation
- State machine with three states: REQ, WAIT, HOLD. There is at most one outstanding memory request.
- **REQ:**
  - `imem_req_valid`=1.
  - When `imem_req_ready`=1, go to WAIT.
- **WAIT:** `imem_req_valid`=0. Wait for `imem_rsp_valid`, then handle the response as follows:
  - If `kill`=1, discard the response, clear `kill`, go to REQ.
  - Otherwise, if the slot is free (`if_valid`=0 or `id_ready`=1), load IF/ID with {data, PC, PC+4}, set `PC <= Next_PC`, go to REQ.
  - Otherwise, store the response in a one-entry skid buffer and go to HOLD.
- **HOLD:**
  - When `id_ready`=1, move the skid entry into IF/ID, set `PC <= Next_PC`, go to REQ.
- **Slot drain:** when `id_ready`=1 and no new entry is loaded, clear `if_valid`.
- **Redirect** has priority over everything else:
  - `PC <= Next_PC` and `if_valid <= 0`. The skid buffer is dropped.
  - In HOLD or WAIT, next state is REQ. The exception is WAIT with no response this cycle: stay in WAIT with `kill`=1.
  - In REQ with `imem_req_ready`=1 the same cycle, the old-PC request is accepted: go to WAIT with `kill`=1.
  - Redirect overrides `id_ready`.
- **Arithmetic:**
  - All adds are 32-bit modulo, so `PC_add_4` of 32'hFFFF_FFFC is 0.
  - `PC[1:0]` is carried unchanged. The address is force-aligned.

## Timing
- **Reset values:**
  - `PC`=`RESET_PC`, state=REQ, `kill`=0.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_add_4`=0.
  - `imem_req_valid`=0 while `rst_n`=0.
- **First request:** `imem_req_valid`=1 in the first cycle after `rst_n` rises.
- **Zero-wait memory** (ready=1, response one cycle after acceptance):
  - `if_valid` rises 2 cycles after the request is accepted.
  - Throughput is one instruction per 2 cycles.
- **Reset mid-operation:** all state returns to reset values immediately. Any response arriving after reset is ignored because the state is REQ.
- **`PC_add_4`** is combinational from the `PC` register, so the mux path is register→adder→mux→`Next_PC` within one cycle.
- **Outputs:**
  - All `if_*` outputs are registered.
  - `imem_req_valid` and `imem_addr` are decoded from registered state and `PC`.

## Test plan
- **Reset and sequential fetch:**
  - Stimulus: `RESET_PC`=0x100; zero-wait memory; `Next_PC`=`PC_add_4`; `id_ready`=1.
  - Required: `imem_addr` = 0x100, 0x104, 0x108; `if_pc` matches each address; `if_pc_add_4` = `if_pc` + 4.
- **Decode stall:**
  - Stimulus: `id_ready`=0 for 5 cycles after the first instruction.
  - Required: the second response goes to the skid buffer (HOLD); `if_instr` stays stable; after `id_ready`=1 the order is preserved with no loss or duplicate.
- **Redirect while waiting:**
  - Stimulus: `redirect`=1 with `Next_PC`=0x400 in WAIT; the response arrives 3 cycles later.
  - Required: that response is discarded; the next `imem_addr` = 0x400; `if_valid`=0 until the 0x400 instruction arrives.
- **Redirect in REQ with `imem_req_ready`=1 in the same cycle:**
  - Required: the stale response is dropped; the next request goes to `Next_PC`.
- **Wrap-around:**
  - Stimulus: `PC`=0xFFFF_FFFC.
  - Required: `PC_add_4`=0; the next fetch address is 0.
- **Async reset mid-WAIT:**
  - Stimulus: assert `rst_n` low between clock edges.
  - Required: outputs go to reset values without waiting for a clock edge; the late `imem_rsp_valid` has no effect; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Purpose : instruction-fetch stage; owns the PC, issues one imem request at a time, fills the IF/ID register.
// Latency : zero-wait memory gives IF/ID valid 2 cycles after request acceptance (1 instruction per 2 cycles).
// Backpr. : imem_req_ready stalls REQ; id_ready=0 parks a returning word in a 1-entry skid (HOLD), no new request.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   Next_PC, redirect          next PC from the select mux; redirect flushes IF/ID and refetches from Next_PC
//   PC, PC_add_4               current fetch PC and its combinational +4 (feeds the mux)
//   imem_req_valid/ready/addr  fetch request (word-aligned address)
//   imem_rsp_valid/data        fetch response
//   if_valid/instr/pc/pc_add_4 registered IF/ID entry
//   id_ready                   decode consumes the IF/ID entry this cycle
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Next_PC,
  input  logic        redirect,
  output logic [31:0] PC,
  output logic [31:0] PC_add_4,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_add_4,
  input  logic        id_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        kill, kill_nxt;
  logic [31:0] pc_q;
  logic [31:0] skid_dat;

  // Control strobes decoded from the FSM for the datapath registers.
  logic        pc_load;
  logic        slot_load;
  logic        slot_from_skid;
  logic        skid_load;
  logic        slot_free;

  assign PC        = pc_q;
  assign PC_add_4  = pc_q + 32'd4;
  assign imem_addr = {pc_q[31:2], 2'b00};

  // Gated with rst_n so the request is low for the whole reset interval,
  // not just after the first clock edge.
  assign imem_req_valid = rst_n && (state == S_REQ);

  // The IF/ID slot can take a new entry if it is empty or being consumed.
  assign slot_free = !if_valid || id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    kill_nxt       = kill;
    pc_load        = 1'b0;
    slot_load      = 1'b0;
    slot_from_skid = 1'b0;
    skid_load      = 1'b0;

    case (state)
      S_REQ: begin
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
          // A redirect in the acceptance cycle means the request just sent
          // carries the old PC; its response must be thrown away.
          kill_nxt  = redirect;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
          kill_nxt  = 1'b0;
          if (!kill && !redirect) begin
            if (slot_free) begin
              slot_load = 1'b1;
              pc_load   = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_nxt = S_HOLD;
            end
          end
        end else if (redirect) begin
          // Response still in flight for a stale PC: remember to drop it.
          kill_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_nxt = S_REQ;
        end else if (id_ready) begin
          state_nxt      = S_REQ;
          slot_load      = 1'b1;
          slot_from_skid = 1'b1;
          pc_load        = 1'b1;
        end
      end

      default: begin
        state_nxt = S_REQ;
        kill_nxt  = 1'b0;
      end
    endcase

    if (redirect) begin
      pc_load = 1'b1;
    end
  end

  // PC only advances once its instruction has entered IF/ID, so while a word
  // sits in the skid buffer PC still names that word's address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (pc_load) begin
      pc_q <= Next_PC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_dat <= 32'd0;
    end else if (skid_load) begin
      skid_dat <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      if_pc_add_4 <= 32'd0;
    end else begin
      if (redirect) begin
        if_valid <= 1'b0;
      end else if (slot_load) begin
        if_valid <= 1'b1;
      end else if (id_ready) begin
        if_valid <= 1'b0;
      end

      if (slot_load) begin
        if_instr    <= slot_from_skid ? skid_dat : imem_rsp_data;
        if_pc       <= pc_q;
        if_pc_add_4 <= PC_add_4;
      end
    end
  end

endmodule
